// File: rtl/drac_pkg.sv
// Shared rename-stage types: physical register IDs, checkpoint versions and
// free-list pointers with a wrap bit above the index bits.
package drac_pkg;

  localparam int NUM_ISA_REGISTERS  = 32;
  localparam int NUM_PHYS_REGISTERS = 64;
  localparam int NUM_CHECKPOINTS    = 4;
  localparam int NUM_FREE           = NUM_PHYS_REGISTERS - NUM_ISA_REGISTERS;

  localparam int PHREG_W    = $clog2(NUM_PHYS_REGISTERS);
  localparam int CKPT_W     = $clog2(NUM_CHECKPOINTS);
  localparam int FREE_IDX_W = $clog2(NUM_FREE);

  typedef logic [PHREG_W-1:0]  phreg_t;
  typedef logic [CKPT_W-1:0]   checkpoint_ptr;
  typedef logic [FREE_IDX_W:0] free_ptr_t;

  function automatic free_ptr_t popcount2(input logic [1:0] v);
    return free_ptr_t'(v[0]) + free_ptr_t'(v[1]);
  endfunction

endpackage

// File: rtl/free_list_ckpt_checkpoint_ctrl.sv
// Checkpoint version bookkeeping (head, tail, live count) shared with the rename table.
// Single-cycle update; a checkpoint request is ignored when no version is free.
module checkpoint_ctrl
  import drac_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              do_checkpoint_i,
  input  logic              do_recover_i,
  input  logic              recover_commit_i,
  input  logic              delete_checkpoint_i,
  input  logic [CKPT_W-1:0] recover_checkpoint_i,
  output logic              checkpoint_en_o,
  output logic [CKPT_W-1:0] version_head_o,
  output logic              out_of_checkpoints_o
);

  logic [CKPT_W-1:0] version_head_q, version_head_d;
  logic [CKPT_W-1:0] version_tail_q, version_tail_d;
  logic [CKPT_W-1:0] num_checkpoints_q, num_checkpoints_d;

  always_comb begin
    checkpoint_en_o = do_checkpoint_i & ~do_recover_i & ~recover_commit_i &
                      (num_checkpoints_q < CKPT_W'(NUM_CHECKPOINTS-1));
    version_head_d    = version_head_q + CKPT_W'(checkpoint_en_o);
    version_tail_d    = version_tail_q + CKPT_W'(delete_checkpoint_i);
    num_checkpoints_d = num_checkpoints_q + CKPT_W'(checkpoint_en_o)
                        - CKPT_W'(delete_checkpoint_i);
    if (recover_commit_i) begin
      version_head_d    = '0;
      version_tail_d    = '0;
      num_checkpoints_d = '0;
    end else if (do_recover_i) begin
      version_head_d    = recover_checkpoint_i;
      // Version count is a power of two, so the modular difference handles wrap.
      num_checkpoints_d = recover_checkpoint_i - version_tail_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      version_head_q    <= '0;
      version_tail_q    <= '0;
      num_checkpoints_q <= '0;
    end else begin
      version_head_q    <= version_head_d;
      version_tail_q    <= version_tail_d;
      num_checkpoints_q <= num_checkpoints_d;
    end
  end

  assign version_head_o       = version_head_q;
  assign out_of_checkpoints_o = (num_checkpoints_q == CKPT_W'(NUM_CHECKPOINTS-1));

endmodule

// File: rtl/free_list_ckpt.sv
// Checkpointed circular free list of physical registers; zero-latency allocate, frees visible next cycle.
// No backpressure: allocation while empty and frees beyond capacity are dropped. Optional checks: FREE_LIST_CHECK_EN.
module free_list_ckpt
  import drac_pkg::*;
(
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    read_head_i,
  input  logic [1:0]              add_free_register_i,
  input  logic [1:0][PHREG_W-1:0] old_register_i,
  input  logic [1:0]              commit_alloc_i,
  input  logic                    recover_commit_i,
  input  logic                    do_checkpoint_i,
  input  logic                    do_recover_i,
  input  logic                    delete_checkpoint_i,
  input  logic [CKPT_W-1:0]       recover_checkpoint_i,
  output logic [PHREG_W-1:0]      new_register_o,
  output logic [CKPT_W-1:0]       checkpoint_o,
  output logic                    out_of_checkpoints_o,
  output logic                    empty_o
);

  phreg_t    fifo_q [NUM_FREE];
  phreg_t    fifo_d [NUM_FREE];
  free_ptr_t head_q [NUM_CHECKPOINTS];
  free_ptr_t head_d [NUM_CHECKPOINTS];
  free_ptr_t tail_q, tail_d;
  free_ptr_t commit_head_q, commit_head_d;

  checkpoint_ptr version_head;
  checkpoint_ptr version_next;
  logic          checkpoint_en;
  free_ptr_t     cur_head;
  free_ptr_t     free_count;
  free_ptr_t     alloc_head;
  free_ptr_t     occupancy;
  logic          alloc_en;
  logic [1:0]    free_vld;
`ifdef FREE_LIST_CHECK_EN
  logic          free_drop;
`endif

  checkpoint_ctrl u_checkpoint_ctrl (
    .clk_i                (clk_i),
    .rst_i                (rst_i),
    .do_checkpoint_i      (do_checkpoint_i),
    .do_recover_i         (do_recover_i),
    .recover_commit_i     (recover_commit_i),
    .delete_checkpoint_i  (delete_checkpoint_i),
    .recover_checkpoint_i (recover_checkpoint_i),
    .checkpoint_en_o      (checkpoint_en),
    .version_head_o       (version_head),
    .out_of_checkpoints_o (out_of_checkpoints_o)
  );

  always_comb begin
    version_next   = version_head + checkpoint_ptr'(1);
    cur_head       = head_q[version_head];
    free_count     = tail_q - cur_head;
    empty_o        = (free_count == '0);
    new_register_o = fifo_q[cur_head[FREE_IDX_W-1:0]];
    alloc_en       = read_head_i & ~empty_o & ~do_recover_i & ~recover_commit_i;
    alloc_head     = cur_head + free_ptr_t'(alloc_en);

    for (int k = 0; k < 2; k++) begin
      free_vld[k] = add_free_register_i[k] & (old_register_i[k] != '0);
    end

    // Fullness uses the pre-allocation count; a same-cycle allocation does not make room.
    fifo_d    = fifo_q;
    tail_d    = tail_q;
    occupancy = free_count;
`ifdef FREE_LIST_CHECK_EN
    free_drop = 1'b0;
`endif
    for (int k = 0; k < 2; k++) begin
      if (free_vld[k]) begin
        if (occupancy >= free_ptr_t'(NUM_FREE)) begin
`ifdef FREE_LIST_CHECK_EN
          free_drop = 1'b1;
`endif
        end else begin
          fifo_d[tail_d[FREE_IDX_W-1:0]] = old_register_i[k];
          tail_d    = tail_d + free_ptr_t'(1);
          occupancy = occupancy + free_ptr_t'(1);
        end
      end
    end

    commit_head_d = commit_head_q + popcount2(commit_alloc_i);

    head_d = head_q;
    if (recover_commit_i) begin
      head_d[0] = commit_head_d;
    end else begin
      head_d[version_head] = alloc_head;
      if (checkpoint_en) begin
        head_d[version_next] = alloc_head;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_FREE; i++) begin
        fifo_q[i] <= phreg_t'(NUM_ISA_REGISTERS + i);
      end
      for (int v = 0; v < NUM_CHECKPOINTS; v++) begin
        head_q[v] <= '0;
      end
      tail_q        <= free_ptr_t'(NUM_FREE);
      commit_head_q <= '0;
    end else begin
      fifo_q        <= fifo_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      commit_head_q <= commit_head_d;
    end
  end

  assign checkpoint_o = version_head;

`ifdef FREE_LIST_CHECK_EN
  (* keep = "true" *) logic err_overflow_q;
  (* keep = "true" *) logic err_alloc_empty_q;
  (* keep = "true" *) logic err_commit_pass_q;

  free_ptr_t commit_adv;
  free_ptr_t commit_room;

  always_comb begin
    commit_adv  = commit_head_d - commit_head_q;
    commit_room = alloc_head - commit_head_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_overflow_q    <= 1'b0;
      err_alloc_empty_q <= 1'b0;
      err_commit_pass_q <= 1'b0;
    end else begin
      err_overflow_q    <= err_overflow_q | free_drop;
      err_alloc_empty_q <= err_alloc_empty_q | (read_head_i & empty_o);
      err_commit_pass_q <= err_commit_pass_q | (commit_adv > commit_room);
    end
  end
`endif

endmodule

// File: tb/tb_free_list_ckpt.sv
// Randomized and directed bench for free_list_ckpt with an integer-pointer reference model
// and a scoreboard queue drained by an independent output monitor.
module tb_free_list_ckpt;
  import drac_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic             read_head;
  logic [1:0]       add_free;
  logic [1:0][5:0]  old_reg;
  logic [1:0]       commit_alloc;
  logic             recover_commit;
  logic             do_checkpoint;
  logic             do_recover;
  logic             delete_checkpoint;
  logic [1:0]       recover_checkpoint;
  logic [5:0]       new_register;
  logic [1:0]       checkpoint;
  logic             out_of_checkpoints;
  logic             empty;

  always #5 clk = ~clk;

  free_list_ckpt dut (
    .clk_i                (clk),
    .rst_i                (rst),
    .read_head_i          (read_head),
    .add_free_register_i  (add_free),
    .old_register_i       (old_reg),
    .commit_alloc_i       (commit_alloc),
    .recover_commit_i     (recover_commit),
    .do_checkpoint_i      (do_checkpoint),
    .do_recover_i         (do_recover),
    .delete_checkpoint_i  (delete_checkpoint),
    .recover_checkpoint_i (recover_checkpoint),
    .new_register_o       (new_register),
    .checkpoint_o         (checkpoint),
    .out_of_checkpoints_o (out_of_checkpoints),
    .empty_o              (empty)
  );

  typedef struct packed {
    logic [5:0] nr;
    logic       emp;
    logic [1:0] ck;
    logic       ooc;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: unbounded integer pointers, modular storage index.
  logic [5:0] m_mem [32];
  int m_tail, m_ch, m_vh, m_vt, m_nck;
  int m_head [4];

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_mem[i] = 6'(32 + i);
    for (int v = 0; v < 4; v++) m_head[v] = 0;
    m_tail = 32;
    m_ch   = 0;
    m_vh   = 0;
    m_vt   = 0;
    m_nck  = 0;
  endtask

  task automatic drive_idle();
    read_head          = 1'b0;
    add_free           = 2'b00;
    old_reg            = '0;
    commit_alloc       = 2'b00;
    recover_commit     = 1'b0;
    do_checkpoint      = 1'b0;
    do_recover         = 1'b0;
    delete_checkpoint  = 1'b0;
    recover_checkpoint = 2'd0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    drive_idle();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic step(input bit rd, input bit [1:0] add, input bit [5:0] o0, input bit [5:0] o1,
                      input bit [1:0] ca, input bit rc, input bit ck, input bit rec,
                      input bit [1:0] rck, input bit del);
    int   cur, cnt, acc, h;
    bit   alloc, ce;
    exp_t e;
    @(posedge clk); #1;
    read_head          = rd;
    add_free           = add;
    old_reg[0]         = o0;
    old_reg[1]         = o1;
    commit_alloc       = ca;
    recover_commit     = rc;
    do_checkpoint      = ck;
    do_recover         = rec;
    recover_checkpoint = rck;
    delete_checkpoint  = del;

    cur   = m_head[m_vh];
    cnt   = m_tail - cur;
    e.nr  = m_mem[cur % 32];
    e.emp = (cnt == 0);
    e.ck  = 2'(m_vh);
    e.ooc = (m_nck == 3);
    sbq.push_back(e);

    alloc = rd && (cnt != 0) && !rec && !rc;
    acc = 0;
    if (add[0] && o0 != 0 && cnt + acc < 32) begin
      m_mem[m_tail % 32] = o0; m_tail++; acc++;
    end
    if (add[1] && o1 != 0 && cnt + acc < 32) begin
      m_mem[m_tail % 32] = o1; m_tail++; acc++;
    end
    m_ch += int'(ca[0]) + int'(ca[1]);
    if (rc) begin
      m_head[0] = m_ch;
      m_vh = 0; m_vt = 0; m_nck = 0;
    end else if (rec) begin
      m_nck = (int'(rck) - m_vt + 4) % 4;
      m_vh  = rck;
      m_vt  = (m_vt + int'(del)) % 4;
    end else begin
      ce = ck && (m_nck < 3);
      h  = cur + int'(alloc);
      m_head[m_vh] = h;
      if (ce) m_head[(m_vh + 1) % 4] = h;
      m_vh  = (m_vh + int'(ce)) % 4;
      m_nck = m_nck + int'(ce) - int'(del);
      m_vt  = (m_vt + int'(del)) % 4;
    end
  endtask

  task automatic alloc_n(input int n);
    for (int i = 0; i < n; i++) step(1, 2'b00, 0, 0, 2'b00, 0, 0, 0, 2'd0, 0);
  endtask

  // Output monitor: every scoreboard entry is checked against the DUT mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        n_checks++;
        if (new_register !== e.nr) begin
          n_fail++;
          $display("FAIL new_register: got %0d expected %0d at %0t", new_register, e.nr, $time);
        end
        n_checks++;
        if (empty !== e.emp) begin
          n_fail++;
          $display("FAIL empty: got %0b expected %0b at %0t", empty, e.emp, $time);
        end
        n_checks++;
        if (checkpoint !== e.ck) begin
          n_fail++;
          $display("FAIL checkpoint: got %0d expected %0d at %0t", checkpoint, e.ck, $time);
        end
        n_checks++;
        if (out_of_checkpoints !== e.ooc) begin
          n_fail++;
          $display("FAIL out_of_checkpoints: got %0b expected %0b at %0t",
                   out_of_checkpoints, e.ooc, $time);
        end
      end
    end
  end

  initial begin
    int avail, k, off, v, budget, r;
    bit rd, rc, rec, ck, del;
    bit [1:0] ca, add, rck;
    bit [5:0] o0, o1;

    rst = 1'b1;
    drive_idle();

    // Reset state, drain all 32 entries, then one request while empty.
    do_reset();
    alloc_n(33);
    step(0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 2'd0, 0);

    // Frees while empty; a zero register is ignored.
    step(0, 2'b11, 6'd5, 6'd9, 2'b00, 0, 0, 0, 2'd0, 0);
    step(0, 2'b01, 6'd0, 6'd0, 2'b00, 0, 0, 0, 2'd0, 0);
    alloc_n(3);

    // Checkpoint with simultaneous allocate, then recover to versions 1 and 0.
    do_reset();
    alloc_n(2);
    step(1, 2'b00, 0, 0, 2'b00, 0, 1, 0, 2'd0, 0);
    alloc_n(2);
    step(0, 2'b00, 0, 0, 2'b00, 0, 0, 1, 2'd1, 0);
    alloc_n(1);
    step(0, 2'b00, 0, 0, 2'b00, 0, 0, 1, 2'd0, 0);
    alloc_n(2);

    // Checkpoint exhaustion and release.
    do_reset();
    for (int i = 0; i < 4; i++) step(0, 2'b00, 0, 0, 2'b00, 0, 1, 0, 2'd0, 0);
    step(0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 2'd0, 1);
    step(0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 2'd0, 0);

    // Exception recovery after two commits.
    do_reset();
    alloc_n(3);
    step(1, 2'b00, 0, 0, 2'b00, 0, 1, 0, 2'd0, 0);
    alloc_n(2);
    step(0, 2'b00, 0, 0, 2'b11, 0, 0, 0, 2'd0, 0);
    step(0, 2'b00, 0, 0, 2'b00, 1, 0, 0, 2'd0, 0);
    alloc_n(2);

    // Overflow: a free at full count is dropped.
    do_reset();
    step(0, 2'b01, 6'd40, 6'd0, 2'b00, 0, 0, 0, 2'd0, 0);
    step(0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 2'd0, 0);
`ifdef FREE_LIST_CHECK_EN
    n_checks++;
    if (dut.err_overflow_q !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_flag: got %0b expected 1", dut.err_overflow_q);
    end
`endif
    alloc_n(33);

    // Randomized traffic with a mid-run reset.
    do_reset();
    for (int c = 0; c < 1600; c++) begin
      if (c == 800) begin
        alloc_n(5);
        do_reset();
      end
      rd  = ($urandom % 10) < 6;
      rc  = ($urandom % 40) == 0;
      ck  = ($urandom % 5) == 0;
      avail = m_head[m_vh] - m_ch;
      k = $urandom % 3;
      if (k > avail) k = (avail < 0) ? 0 : avail;
      ca = (k == 2) ? 2'b11 : (k == 1) ? (($urandom % 2) ? 2'b01 : 2'b10) : 2'b00;
      rec = !rc && (($urandom % 12) == 0);
      rck = 2'd0;
      if (rec) begin
        off = $urandom % (m_nck + 1);
        v   = (m_vt + off) % 4;
        if (m_head[v] >= m_ch + k) rck = 2'(v);
        else rec = 0;
      end
      del = !rc && !rec && (m_nck > 0) && (($urandom % 6) == 0);
      budget = 32 - (m_tail - m_ch);
      add = 2'b00; o0 = 0; o1 = 0;
      r = $urandom % 4;
      if (r == 1) add[0] = 1;
      else if (r >= 2 && budget > 0) begin add[0] = 1; o0 = 6'(1 + $urandom % 63); budget--; end
      r = $urandom % 4;
      if (r == 1) add[1] = 1;
      else if (r >= 2 && budget > 0) begin add[1] = 1; o1 = 6'(1 + $urandom % 63); budget--; end
      step(rd, add, o0, o1, ca, rc, ck, rec, rck, del);
    end

    @(posedge clk); #1;
    drive_idle();
    repeat (3) @(negedge clk);
    n_checks++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
